ex_mem_stage: RTL and testbench

- Parametrised EX->MEM pipeline register for the OpenMIPS core.
- Successor to the fixed-width EX/MEM latch. It generalises data, address and stall-bus widths and the multi-cycle counter width.
- Adds a flush input, a valid flag, and a saturating hold-cycle counter.
- Carries the multi-cycle HI/LO scratch (madd/msub/div) and the cycle counter back to EX while EX is stalled.

---
 rtl/ex_mem_stage.sv | 136 +++++++++++++
 tb/tb_ex_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with flush, valid flag and saturating hold counter.
// Also returns the multi-cycle HI/LO scratch and cycle count to EX while EX is stalled.
module ex_mem_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned STALL_WIDTH    = 6,
    parameter int unsigned STAGE_INDEX    = 3,
    parameter int unsigned CNT_WIDTH      = 2,
    parameter int unsigned HOLD_CNT_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [STALL_WIDTH-1:0]    stop_all,
    input  logic [REG_ADDR_WIDTH-1:0] ex_write_reg_address_input,
    input  logic                      ex_write_reg_enable_input,
    input  logic [DATA_WIDTH-1:0]     ex_write_reg_data_input,
    input  logic [DATA_WIDTH-1:0]     ex_hi_input,
    input  logic [DATA_WIDTH-1:0]     ex_lo_input,
    input  logic                      ex_whilo_input,
    input  logic [2*DATA_WIDTH-1:0]   hilo_input,
    input  logic [CNT_WIDTH-1:0]      count_clock_input,
    output logic                      mem_valid_output,
    output logic [REG_ADDR_WIDTH-1:0] mem_write_reg_address_output,
    output logic                      mem_write_reg_enable_output,
    output logic [DATA_WIDTH-1:0]     mem_write_reg_data_output,
    output logic [DATA_WIDTH-1:0]     mem_hi_output,
    output logic [DATA_WIDTH-1:0]     mem_lo_output,
    output logic                      mem_whilo_output,
    output logic [2*DATA_WIDTH-1:0]   hilo_output,
    output logic [CNT_WIDTH-1:0]      count_clock_output,
    output logic [HOLD_CNT_WIDTH-1:0] hold_cycles_output
);

    logic stall_self, stall_next;
    logic unused_stop_bits;

    assign stall_self       = stop_all[STAGE_INDEX];
    assign stall_next       = stop_all[STAGE_INDEX+1];
    assign unused_stop_bits = ^stop_all;

    logic                      valid_q, valid_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     hi_q, hi_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic                      whilo_q, whilo_d;
    logic [2*DATA_WIDTH-1:0]   hilo_q, hilo_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [HOLD_CNT_WIDTH-1:0] hold_q, hold_d;

    always_comb begin
        valid_d = valid_q;
        waddr_d = waddr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        whilo_d = whilo_q;
        hilo_d  = hilo_input;
        cnt_d   = count_clock_input;
        hold_d  = '0;

        if (flush) begin
            valid_d = 1'b0;
            waddr_d = '0;
            we_d    = 1'b0;
            wdata_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            whilo_d = 1'b0;
            hilo_d  = '0;
            cnt_d   = '0;
        end else if (!stall_self) begin
            // S=0,N=1 cannot occur legally; it falls through to a normal advance
            valid_d = 1'b1;
            waddr_d = ex_write_reg_address_input;
            we_d    = ex_write_reg_enable_input;
            wdata_d = ex_write_reg_data_input;
            hi_d    = ex_hi_input;
            lo_d    = ex_lo_input;
            whilo_d = ex_whilo_input;
            cnt_d   = '0;
        end else if (!stall_next) begin
            valid_d = 1'b0;
            waddr_d = '0;
            we_d    = 1'b0;
            wdata_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            whilo_d = 1'b0;
        end else begin
            hold_d = (hold_q == '1) ? hold_q
                                    : hold_q + {{(HOLD_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            waddr_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            whilo_q <= 1'b0;
            hilo_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            whilo_q <= whilo_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign mem_valid_output             = valid_q;
    assign mem_write_reg_address_output = waddr_q;
    assign mem_write_reg_enable_output  = we_q;
    assign mem_write_reg_data_output    = wdata_q;
    assign mem_hi_output                = hi_q;
    assign mem_lo_output                = lo_q;
    assign mem_whilo_output             = whilo_q;
    assign hilo_output                  = hilo_q;
    assign count_clock_output           = cnt_q;
    assign hold_cycles_output           = hold_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: default, 2-bit hold counter and 64-bit/STAGE_INDEX=1 builds.
module tb_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [5:0]  stop_all;
    logic [4:0]  ex_addr;
    logic        ex_we;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_in;
    logic [1:0]  cnt_in;

    logic        d_valid, d_we, d_whilo;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata, d_hi, d_lo;
    logic [63:0] d_hilo;
    logic [1:0]  d_cnt;
    logic [7:0]  d_hold;

    logic        s_valid, s_we, s_whilo;
    logic [4:0]  s_addr;
    logic [31:0] s_wdata, s_hi, s_lo;
    logic [63:0] s_hilo;
    logic [1:0]  s_cnt;
    logic [1:0]  s_hold;

    logic [3:0]   w_stop;
    logic [63:0]  w_wdata_in, w_hi_in, w_lo_in;
    logic [127:0] w_hilo_in;
    logic         w_valid, w_we, w_whilo;
    logic [4:0]   w_addr;
    logic [63:0]  w_wdata, w_hi, w_lo;
    logic [127:0] w_hilo;
    logic [1:0]   w_cnt;
    logic [7:0]   w_hold;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ex_mem_stage dut (
        .clock(clock), .reset(reset), .flush(flush), .stop_all(stop_all),
        .ex_write_reg_address_input(ex_addr), .ex_write_reg_enable_input(ex_we),
        .ex_write_reg_data_input(ex_wdata), .ex_hi_input(ex_hi), .ex_lo_input(ex_lo),
        .ex_whilo_input(ex_whilo), .hilo_input(hilo_in), .count_clock_input(cnt_in),
        .mem_valid_output(d_valid), .mem_write_reg_address_output(d_addr),
        .mem_write_reg_enable_output(d_we), .mem_write_reg_data_output(d_wdata),
        .mem_hi_output(d_hi), .mem_lo_output(d_lo), .mem_whilo_output(d_whilo),
        .hilo_output(d_hilo), .count_clock_output(d_cnt), .hold_cycles_output(d_hold)
    );

    ex_mem_stage #(.HOLD_CNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .flush(flush), .stop_all(stop_all),
        .ex_write_reg_address_input(ex_addr), .ex_write_reg_enable_input(ex_we),
        .ex_write_reg_data_input(ex_wdata), .ex_hi_input(ex_hi), .ex_lo_input(ex_lo),
        .ex_whilo_input(ex_whilo), .hilo_input(hilo_in), .count_clock_input(cnt_in),
        .mem_valid_output(s_valid), .mem_write_reg_address_output(s_addr),
        .mem_write_reg_enable_output(s_we), .mem_write_reg_data_output(s_wdata),
        .mem_hi_output(s_hi), .mem_lo_output(s_lo), .mem_whilo_output(s_whilo),
        .hilo_output(s_hilo), .count_clock_output(s_cnt), .hold_cycles_output(s_hold)
    );

    ex_mem_stage #(.DATA_WIDTH(64), .STAGE_INDEX(1), .STALL_WIDTH(4)) dut_wide (
        .clock(clock), .reset(reset), .flush(flush), .stop_all(w_stop),
        .ex_write_reg_address_input(ex_addr), .ex_write_reg_enable_input(ex_we),
        .ex_write_reg_data_input(w_wdata_in), .ex_hi_input(w_hi_in), .ex_lo_input(w_lo_in),
        .ex_whilo_input(ex_whilo), .hilo_input(w_hilo_in), .count_clock_input(cnt_in),
        .mem_valid_output(w_valid), .mem_write_reg_address_output(w_addr),
        .mem_write_reg_enable_output(w_we), .mem_write_reg_data_output(w_wdata),
        .mem_hi_output(w_hi), .mem_lo_output(w_lo), .mem_whilo_output(w_whilo),
        .hilo_output(w_hilo), .count_clock_output(w_cnt), .hold_cycles_output(w_hold)
    );

    // Stall vectors must be monotone toward earlier stages.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(!stop_all[3] && stop_all[4])) else $error("illegal stop_all %b", stop_all);
            assert (!(!w_stop[1] && w_stop[2])) else $error("illegal w_stop %b", w_stop);
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        logic [207:0] obs;
        step();
        step();
        obs = {d_valid, d_addr, d_we, d_wdata, d_hi, d_lo, d_whilo, d_hilo, d_cnt, d_hold};
        if (obs !== '0) begin
            $display("FAIL reset_initial: got %h want 0", obs);
            n_err++;
        end
        n_vec++;

        reset = 1'b0;
        ex_addr = 5'd5; ex_we = 1'b1; ex_wdata = 32'hDEADBEEF;
        ex_hi = 32'h11; ex_lo = 32'h22; ex_whilo = 1'b1;
        hilo_in = 64'hA; cnt_in = 2'd3;
        step();
        if ({d_valid, d_addr, d_we, d_wdata, d_cnt} !== {1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 2'd0}) begin
            $display("FAIL reset_first_advance: got v=%b a=%0d we=%b d=%h c=%0d want v=1 a=5 we=1 d=deadbeef c=0",
                     d_valid, d_addr, d_we, d_wdata, d_cnt);
            n_err++;
        end
        n_vec++;
        if ({d_hi, d_lo, d_whilo, d_hilo} !== {32'h11, 32'h22, 1'b1, 64'hA}) begin
            $display("FAIL reset_hilo_path: got hi=%h lo=%h wh=%b hilo=%h want 11 22 1 a",
                     d_hi, d_lo, d_whilo, d_hilo);
            n_err++;
        end
        n_vec++;

        stop_all = 6'b011000;
        step();
        if ({d_cnt, d_hold, d_valid} !== {2'd3, 8'd1, 1'b1}) begin
            $display("FAIL reset_prestall: got c=%0d h=%0d v=%b want c=3 h=1 v=1", d_cnt, d_hold, d_valid);
            n_err++;
        end
        n_vec++;

        // Asynchronous reset in the middle of a held multi-cycle op.
        reset = 1'b1;
        #2;
        obs = {d_valid, d_addr, d_we, d_wdata, d_hi, d_lo, d_whilo, d_hilo, d_cnt, d_hold};
        if (obs !== '0 || s_hold !== 2'd0 || w_valid !== 1'b0) begin
            $display("FAIL reset_async_mid_stall: got %h s_hold=%0d w_valid=%b want 0", obs, s_hold, w_valid);
            n_err++;
        end
        n_vec++;
        reset = 1'b0;
        stop_all = 6'b0;
        step();
    endtask

    task automatic test_bubble;
        ex_addr = 5'd9; ex_we = 1'b1; ex_wdata = 32'h99; ex_whilo = 1'b1;
        stop_all = 6'b0;
        step();
        stop_all = 6'b001000;
        hilo_in = 64'h1_0000_0002; cnt_in = 2'd1;
        step();
        if ({d_valid, d_we, d_addr, d_wdata, d_whilo, d_hilo, d_cnt, d_hold} !==
            {1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 64'h1_0000_0002, 2'd1, 8'd0}) begin
            $display("FAIL bubble_insert: got v=%b we=%b a=%0d d=%h wh=%b hilo=%h c=%0d h=%0d want 0 0 0 0 0 100000002 1 0",
                     d_valid, d_we, d_addr, d_wdata, d_whilo, d_hilo, d_cnt, d_hold);
            n_err++;
        end
        n_vec++;
        cnt_in = 2'd2;
        step();
        if (d_cnt !== 2'd2 || d_valid !== 1'b0) begin
            $display("FAIL bubble_count: got c=%0d v=%b want c=2 v=0", d_cnt, d_valid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_hold;
        stop_all = 6'b0;
        ex_addr = 5'd7; ex_we = 1'b1; ex_wdata = 32'h55;
        step();
        if ({d_valid, d_addr, d_wdata} !== {1'b1, 5'd7, 32'h55}) begin
            $display("FAIL hold_load: got v=%b a=%0d d=%h want 1 7 55", d_valid, d_addr, d_wdata);
            n_err++;
        end
        n_vec++;
        stop_all = 6'b011000;
        ex_addr = 5'd3; ex_wdata = 32'hAA;
        for (int i = 1; i <= 3; i++) begin
            step();
            if ({d_valid, d_addr, d_wdata, d_hold} !== {1'b1, 5'd7, 32'h55, 8'(i)}) begin
                $display("FAIL hold_cycle%0d: got v=%b a=%0d d=%h h=%0d want 1 7 55 %0d",
                         i, d_valid, d_addr, d_wdata, d_hold, i);
                n_err++;
            end
            n_vec++;
        end
        stop_all = 6'b0;
        step();
        if ({d_hold, d_addr, d_wdata, d_valid} !== {8'd0, 5'd3, 32'hAA, 1'b1}) begin
            $display("FAIL hold_release: got h=%0d a=%0d d=%h v=%b want 0 3 aa 1",
                     d_hold, d_addr, d_wdata, d_valid);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_saturation;
        int exp_s;
        stop_all = 6'b011000;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_s = (i > 3) ? 3 : i;
            if (s_hold !== 2'(exp_s) || d_hold !== 8'(i)) begin
                $display("FAIL saturate_cycle%0d: got s_hold=%0d d_hold=%0d want %0d %0d",
                         i, s_hold, d_hold, exp_s, i);
                n_err++;
            end
            n_vec++;
        end
        stop_all = 6'b0;
        step();
        if (s_hold !== 2'd0) begin
            $display("FAIL saturate_release: got %0d want 0", s_hold);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_flush;
        logic [207:0] obs;
        stop_all = 6'b0;
        ex_addr = 5'd12; ex_we = 1'b1; ex_whilo = 1'b1; ex_wdata = 32'hC0FFEE;
        ex_hi = 32'h1; ex_lo = 32'h2; hilo_in = 64'h3_0000_0004;
        step();
        stop_all = 6'b011000; cnt_in = 2'd3;
        step();
        if ({d_valid, d_addr, d_cnt, d_hold} !== {1'b1, 5'd12, 2'd3, 8'd1}) begin
            $display("FAIL flush_prehold: got v=%b a=%0d c=%0d h=%0d want 1 12 3 1",
                     d_valid, d_addr, d_cnt, d_hold);
            n_err++;
        end
        n_vec++;
        flush = 1'b1;
        step();
        obs = {d_valid, d_addr, d_we, d_wdata, d_hi, d_lo, d_whilo, d_hilo, d_cnt, d_hold};
        if (obs !== '0) begin
            $display("FAIL flush_kill: got %h want 0", obs);
            n_err++;
        end
        n_vec++;
        flush = 1'b0; stop_all = 6'b0;
        ex_addr = 5'd14; ex_wdata = 32'h1234; ex_whilo = 1'b0; hilo_in = 64'h77; cnt_in = 2'd2;
        step();
        if ({d_valid, d_addr, d_wdata, d_whilo, d_hilo, d_cnt} !==
            {1'b1, 5'd14, 32'h1234, 1'b0, 64'h77, 2'd0}) begin
            $display("FAIL flush_resume: got v=%b a=%0d d=%h wh=%b hilo=%h c=%0d want 1 14 1234 0 77 0",
                     d_valid, d_addr, d_wdata, d_whilo, d_hilo, d_cnt);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_params;
        w_stop = 4'b0000;
        w_wdata_in = 64'h0123_4567_89AB_CDEF;
        w_hilo_in = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
        step();
        if ({w_valid, w_wdata, w_hilo} !== {1'b1, 64'h0123_4567_89AB_CDEF,
                                            128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978}) begin
            $display("FAIL wide_pass: got v=%b d=%h hilo=%h", w_valid, w_wdata, w_hilo);
            n_err++;
        end
        n_vec++;
        w_stop = 4'b1000;
        w_wdata_in = 64'h8000_0000_0000_0001;
        step();
        if ({w_valid, w_wdata} !== {1'b1, 64'h8000_0000_0000_0001}) begin
            $display("FAIL wide_bit3_ignored: got v=%b d=%h want 1 8000000000000001", w_valid, w_wdata);
            n_err++;
        end
        n_vec++;
        w_stop = 4'b0010; cnt_in = 2'd1;
        w_hilo_in = 128'h1;
        step();
        if ({w_valid, w_wdata, w_hilo, w_cnt} !== {1'b0, 64'd0, 128'h1, 2'd1}) begin
            $display("FAIL wide_bubble: got v=%b d=%h hilo=%h c=%0d want 0 0 1 1",
                     w_valid, w_wdata, w_hilo, w_cnt);
            n_err++;
        end
        n_vec++;
        w_stop = 4'b0000; w_wdata_in = 64'hAAAA_5555_AAAA_5555;
        step();
        w_stop = 4'b0110; w_wdata_in = 64'h0;
        step();
        w_stop = 4'b1110;
        step();
        if ({w_valid, w_wdata, w_hold} !== {1'b1, 64'hAAAA_5555_AAAA_5555, 8'd2}) begin
            $display("FAIL wide_hold: got v=%b d=%h h=%0d want 1 aaaa5555aaaa5555 2",
                     w_valid, w_wdata, w_hold);
            n_err++;
        end
        n_vec++;
        w_stop = 4'b0000;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stop_all = 6'b0;
        ex_addr = '0; ex_we = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
        hilo_in = '0; cnt_in = '0;
        w_stop = '0; w_wdata_in = '0; w_hi_in = '0; w_lo_in = '0; w_hilo_in = '0;

        test_reset();
        test_bubble();
        test_hold();
        test_saturation();
        test_flush();
        test_params();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
